sar_sequencer: RTL and testbench

- Sits directly upstream and downstream of the SAR ADC core.
- Generates periodic one-cycle start pulses and detects the conversion-done rising edge on the core's ready output.
- Captures each result, averages 2^k consecutive samples (power-of-two oversampling) and presents the averaged word on a valid/ready stream to the system bus or UART path.

---
 rtl/sar_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_sar_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_sequencer.sv
// ---------------------------------------------------------------------------
// sar_sequencer
//   Drives a SAR ADC core with periodic one-cycle start pulses, captures each
//   conversion result on the rising edge of the core's ready level, averages
//   2^k consecutive results and offers the average on a valid/ready stream.
//
//   Optional build macro: SAR_SEQ_ROUND_EN
//     defined   -> average rounds half up: (acc + 2^(k-1)) >> k
//     undefined -> average truncates:      acc >> k
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   en_i          run enable (level)
//   period_i      sample period in clk cycles (raised to RESOLUTION+3 if lower)
//   avg_log2_i    averaging exponent k, clamped to AVG_LOG2_MAX, latched on start
//   clr_i         one-cycle clear of overrun_o
//   start_o       one-cycle start pulse to the SAR core
//   adc_rdy_i     SAR ready level
//   adc_result_i  SAR result, valid when adc_rdy_i rises
//   data_o        averaged sample
//   valid_o       data_o valid
//   ready_i       consumer accepts data_o
//   overrun_o     sticky: average dropped or sample tick missed
// ---------------------------------------------------------------------------
module sar_sequencer #(
    parameter int RESOLUTION   = 8,
    parameter int AVG_LOG2_MAX = 4,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              en_i,
    input  logic [DIV_WIDTH-1:0]              period_i,
    input  logic [$clog2(AVG_LOG2_MAX+1)-1:0] avg_log2_i,
    input  logic                              clr_i,
    output logic                              start_o,
    input  logic                              adc_rdy_i,
    input  logic [RESOLUTION-1:0]             adc_result_i,
    output logic [RESOLUTION-1:0]             data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              overrun_o
);

    localparam int KW = $clog2(AVG_LOG2_MAX + 1);
    localparam int AW = RESOLUTION + AVG_LOG2_MAX + 1;
    localparam int CW = AVG_LOG2_MAX + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TICK = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;

    // Shortest period that keeps a free-running core from being restarted
    // while it is still converting.
    localparam logic [DIV_WIDTH-1:0] P_MIN = DIV_WIDTH'(RESOLUTION + 3);
    localparam logic [KW-1:0]        K_MAX = KW'(AVG_LOG2_MAX);

    // Divide the accumulated sum by 2^k; the spare accumulator bit absorbs
    // the rounding offset so no saturation is needed.
    function automatic logic [RESOLUTION-1:0] average(input logic [AW-1:0] acc,
                                                      input logic [KW-1:0] k);
        logic [AW-1:0] sum;
`ifdef SAR_SEQ_ROUND_EN
        sum = acc + ((AW'(1'b1) << k) >> 1);
`else
        sum = acc;
`endif
        average = RESOLUTION'(sum >> k);
    endfunction

    logic [1:0]            state_r;
    logic [DIV_WIDTH-1:0]  period_cnt_r;
    logic [KW-1:0]         k_r;
    logic [AW-1:0]         acc_r;
    logic [CW-1:0]         smp_cnt_r;
    logic                  rdy_q_r;
    logic                  busy_r;
    logic                  start_r;
    logic                  valid_r;
    logic                  overrun_r;
    logic [RESOLUTION-1:0] data_r;

    logic [DIV_WIDTH-1:0]  period_eff_s;
    logic [DIV_WIDTH-1:0]  period_last_s;
    logic                  tick_s;
    logic [KW-1:0]         k_clamp_s;
    logic                  rdy_rise_s;
    logic                  accept_s;
    logic [AW-1:0]         acc_next_s;
    logic [CW-1:0]         smp_next_s;
    logic                  full_s;
    logic                  emit_s;
    logic [RESOLUTION-1:0] avg_s;
    logic                  load_s;
    logic                  drop_s;
    logic                  miss_s;

    // Period clamp, tick detect, sample capture and output-stream decisions.
    always_comb begin
        if (period_i < P_MIN) begin
            period_eff_s = P_MIN;
        end else begin
            period_eff_s = period_i;
        end
        period_last_s = period_eff_s - DIV_WIDTH'(1'b1);
        tick_s        = (period_cnt_r >= period_last_s);

        if (avg_log2_i > K_MAX) begin
            k_clamp_s = K_MAX;
        end else begin
            k_clamp_s = avg_log2_i;
        end

        rdy_rise_s = adc_rdy_i & ~rdy_q_r;
        accept_s   = (state_r == ST_CONV) & busy_r & rdy_rise_s;
        acc_next_s = acc_r + AW'(adc_result_i);
        smp_next_s = smp_cnt_r + CW'(1'b1);
        full_s     = (smp_next_s == (CW'(1'b1) << k_r));
        emit_s     = accept_s & full_s;
        avg_s      = average(acc_next_s, k_r);
        load_s     = emit_s & (~valid_r | ready_i);
        drop_s     = emit_s & valid_r & ~ready_i;
        // A tick that lands while the core is still converting is skipped.
        miss_s     = (state_r == ST_CONV) & ~accept_s & tick_s;
    end

    // Sequencer state, period counter, accumulator and start pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            period_cnt_r <= '0;
            k_r          <= '0;
            acc_r        <= '0;
            smp_cnt_r    <= '0;
            rdy_q_r      <= 1'b0;
            busy_r       <= 1'b0;
            start_r      <= 1'b0;
        end else begin
            rdy_q_r <= adc_rdy_i;
            case (state_r)
                ST_IDLE: begin
                    start_r      <= 1'b0;
                    busy_r       <= 1'b0;
                    period_cnt_r <= '0;
                    if (en_i) begin
                        k_r       <= k_clamp_s;
                        acc_r     <= '0;
                        smp_cnt_r <= '0;
                        state_r   <= ST_TICK;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_TICK: begin
                    if (!en_i) begin
                        start_r      <= 1'b0;
                        period_cnt_r <= '0;
                        acc_r        <= '0;
                        smp_cnt_r    <= '0;
                        state_r      <= ST_IDLE;
                    end else if (tick_s) begin
                        start_r      <= 1'b1;
                        busy_r       <= 1'b1;
                        period_cnt_r <= '0;
                        state_r      <= ST_CONV;
                    end else begin
                        start_r      <= 1'b0;
                        period_cnt_r <= period_cnt_r + DIV_WIDTH'(1'b1);
                    end
                end
                ST_CONV: begin
                    if (accept_s) begin
                        // Completed group or disable: start the next group empty
                        // (a partial group is discarded on the way to IDLE).
                        if (full_s || !en_i) begin
                            acc_r     <= '0;
                            smp_cnt_r <= '0;
                        end else begin
                            acc_r     <= acc_next_s;
                            smp_cnt_r <= smp_next_s;
                        end
                        if (!en_i) begin
                            start_r      <= 1'b0;
                            busy_r       <= 1'b0;
                            period_cnt_r <= '0;
                            state_r      <= ST_IDLE;
                        end else if (tick_s) begin
                            // Conversion ended exactly on the tick: fire it now.
                            start_r      <= 1'b1;
                            busy_r       <= 1'b1;
                            period_cnt_r <= '0;
                            state_r      <= ST_CONV;
                        end else begin
                            start_r      <= 1'b0;
                            busy_r       <= 1'b0;
                            period_cnt_r <= period_cnt_r + DIV_WIDTH'(1'b1);
                            state_r      <= ST_TICK;
                        end
                    end else begin
                        start_r <= 1'b0;
                        if (tick_s) begin
                            period_cnt_r <= '0;
                        end else begin
                            period_cnt_r <= period_cnt_r + DIV_WIDTH'(1'b1);
                        end
                    end
                end
                default: begin
                    start_r      <= 1'b0;
                    busy_r       <= 1'b0;
                    period_cnt_r <= '0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // Output stream register: load on emit when the slot is free or draining.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load_s) begin
            valid_r <= 1'b1;
            data_r  <= avg_s;
        end else if (valid_r && ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Sticky overrun flag; a new event wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_r <= 1'b0;
        end else if (drop_s || miss_s) begin
            overrun_r <= 1'b1;
        end else if (clr_i) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign start_o   = start_r;
    assign data_o    = data_r;
    assign valid_o   = valid_r;
    assign overrun_o = overrun_r;

endmodule

// File: tb/tb_sar_sequencer.sv
// Testbench for sar_sequencer: SAR core model plus per-scenario tasks that
// compare the stream against averages computed from the raw results.
module tb_sar_sequencer;
    localparam int RES      = 8;
    localparam int AMAX     = 4;
    localparam int DW       = 16;
    localparam int KW       = $clog2(AMAX + 1);
    localparam int CONV_CYC = RES + 2;
    localparam int P_MIN    = RES + 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [DW-1:0]  period;
    logic [KW-1:0]  avg_log2;
    logic           clr;
    logic           start;
    logic           rdy;
    logic [RES-1:0] result;
    logic [RES-1:0] data;
    logic           valid;
    logic           ready;
    logic           overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int cd    = 0;
    logic valid_prev = 1'b0;

    logic [RES-1:0] res_q[$];
    logic [RES-1:0] used_q[$];
    logic [RES-1:0] xfer_q[$];
    int             start_t[$];
    int             rdy_t[$];
    int             vrise_t[$];

    always #5 clk = ~clk;

    sar_sequencer #(.RESOLUTION(RES), .AVG_LOG2_MAX(AMAX), .DIV_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .period_i(period),
        .avg_log2_i(avg_log2), .clr_i(clr), .start_o(start), .adc_rdy_i(rdy),
        .adc_result_i(result), .data_o(data), .valid_o(valid), .ready_i(ready),
        .overrun_o(overrun)
    );

    function automatic int ref_avg(int sum, int kk);
`ifdef SAR_SEQ_ROUND_EN
        if (kk > 0) return (sum + (1 << (kk - 1))) / (1 << kk);
`endif
        return sum / (1 << kk);
    endfunction

    function automatic int eff_period(int p);
        return (p < P_MIN) ? P_MIN : p;
    endfunction

    // One clock: log the transfer at this edge, then sample and model the core.
    task automatic step();
        if (valid === 1'b1 && ready === 1'b1) xfer_q.push_back(data);
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1 && valid_prev !== 1'b1) vrise_t.push_back(cyc);
        valid_prev = valid;
        if (start === 1'b1) begin
            start_t.push_back(cyc);
            rdy = 1'b0;
            cd  = CONV_CYC;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                if (res_q.size() > 0) result = res_q.pop_front();
                else result = RES'($urandom);
                used_q.push_back(result);
                rdy = 1'b1;
                rdy_t.push_back(cyc);
            end
        end
    endtask

    task automatic clear_mon();
        used_q.delete(); xfer_q.delete(); start_t.delete();
        rdy_t.delete(); vrise_t.delete();
        valid_prev = valid;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; ready = 1'b1;
        period = DW'(20); avg_log2 = '0; rdy = 1'b0; result = '0; cd = 0;
        res_q.delete();
        step(); step();
        rst_n = 1'b1;
        step();
        clear_mon();
    endtask

    task automatic test_reset();
        reset_dut();
        if (start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b exp 0", start); end
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b exp 0", valid); end
        n_cmp++;
        if (data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h exp 00", data); end
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b exp 0", overrun); end
        n_cmp++;
    endtask

    task automatic test_periodic();
        int b = 0;
        int c0;
        reset_dut();
        period = DW'(20); avg_log2 = '0; ready = 1'b1;
        repeat (8) res_q.push_back(8'h5A);
        en = 1'b1; c0 = cyc;
        while (start_t.size() < 5 && b < 400) begin step(); b++; end
        repeat (12) step();
        en = 1'b0;
        if (start_t.size() < 5) begin n_bad++; $display("FAIL per_wait: got %0d starts exp 5", start_t.size()); end
        n_cmp++;
        if (start_t.size() >= 5) begin
            if (start_t[0] !== c0 + 21) begin n_bad++; $display("FAIL per_first: got %0d exp %0d", start_t[0], c0 + 21); end
            n_cmp++;
            for (int i = 1; i < 5; i++) begin
                if (start_t[i] - start_t[i-1] !== 20) begin
                    n_bad++; $display("FAIL per_spacing: got %0d exp 20", start_t[i] - start_t[i-1]);
                end
                n_cmp++;
            end
        end
        if (vrise_t.size() !== rdy_t.size()) begin n_bad++; $display("FAIL per_nvalid: got %0d exp %0d", vrise_t.size(), rdy_t.size()); end
        n_cmp++;
        for (int i = 0; i < vrise_t.size() && i < rdy_t.size(); i++) begin
            if (vrise_t[i] !== rdy_t[i] + 1) begin n_bad++; $display("FAIL per_latency: got %0d exp %0d", vrise_t[i], rdy_t[i] + 1); end
            n_cmp++;
        end
        if (xfer_q.size() !== 5) begin n_bad++; $display("FAIL per_nxfer: got %0d exp 5", xfer_q.size()); end
        n_cmp++;
        foreach (xfer_q[i]) begin
            if (xfer_q[i] !== 8'h5A) begin n_bad++; $display("FAIL per_data: got %h exp 5a", xfer_q[i]); end
            n_cmp++;
        end
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL per_overrun: got %b exp 0", overrun); end
        n_cmp++;
        repeat (30) step();
    endtask

    task automatic test_min_period();
        int b = 0;
        int p;
        reset_dut();
        p = int'($urandom_range(0, P_MIN - 1));
        period = DW'(p); avg_log2 = '0; ready = 1'b1;
        en = 1'b1;
        while (start_t.size() < 5 && b < 300) begin step(); b++; end
        repeat (3) step();
        en = 1'b0;
        if (start_t.size() < 5) begin n_bad++; $display("FAIL minp_wait: got %0d starts exp 5", start_t.size()); end
        n_cmp++;
        for (int i = 1; i < start_t.size(); i++) begin
            if (start_t[i] - start_t[i-1] !== P_MIN) begin
                n_bad++; $display("FAIL minp_spacing: period %0d got %0d exp %0d", p, start_t[i] - start_t[i-1], P_MIN);
            end
            n_cmp++;
        end
        for (int i = 0; i < xfer_q.size() && i < used_q.size(); i++) begin
            if (xfer_q[i] !== used_q[i]) begin n_bad++; $display("FAIL minp_data: got %h exp %h", xfer_q[i], used_q[i]); end
            n_cmp++;
        end
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL minp_overrun: got %b exp 0", overrun); end
        n_cmp++;
        repeat (30) step();
    endtask

    task automatic test_average();
        int b = 0;
        int exp_v;
        reset_dut();
        period = DW'(20); avg_log2 = KW'(2); ready = 1'b1;
        res_q.push_back(8'd10); res_q.push_back(8'd11); res_q.push_back(8'd11); res_q.push_back(8'd11);
        en = 1'b1;
        while (rdy_t.size() < 4 && b < 400) begin step(); b++; end
        step(); step();
        en = 1'b0;
        exp_v = ref_avg(43, 2);
        if (xfer_q.size() !== 1) begin n_bad++; $display("FAIL avg_nxfer: got %0d exp 1", xfer_q.size()); end
        else begin
            if (int'(xfer_q[0]) !== exp_v) begin n_bad++; $display("FAIL avg_data: got %0d exp %0d", xfer_q[0], exp_v); end
            n_cmp++;
        end
        n_cmp++;
        if (start_t.size() !== 4) begin n_bad++; $display("FAIL avg_starts: got %0d exp 4", start_t.size()); end
        n_cmp++;
        if (vrise_t.size() !== 1) begin n_bad++; $display("FAIL avg_nvalid: got %0d exp 1", vrise_t.size()); end
        n_cmp++;
        repeat (30) step();

        // Exponent above the maximum is clamped; full-scale samples must not wrap.
        reset_dut();
        b = 0;
        period = DW'(P_MIN); avg_log2 = KW'(7); ready = 1'b1;
        repeat (16) res_q.push_back(8'hFF);
        en = 1'b1;
        while (rdy_t.size() < 16 && b < 400) begin step(); b++; end
        step(); step();
        en = 1'b0;
        exp_v = ref_avg(16 * 255, AMAX);
        if (xfer_q.size() !== 1) begin n_bad++; $display("FAIL clamp_nxfer: got %0d exp 1", xfer_q.size()); end
        else begin
            if (int'(xfer_q[0]) !== exp_v) begin n_bad++; $display("FAIL clamp_data: got %0d exp %0d", xfer_q[0], exp_v); end
            n_cmp++;
        end
        n_cmp++;
        repeat (30) step();
    endtask

    task automatic test_overrun();
        int b = 0;
        reset_dut();
        period = DW'(20); avg_log2 = '0; ready = 1'b0;
        res_q.push_back(8'h10); res_q.push_back(8'h20); res_q.push_back(8'h30);
        en = 1'b1;
        while (rdy_t.size() < 2 && b < 200) begin step(); b++; end
        step();
        if (rdy_t.size() < 2) begin n_bad++; $display("FAIL ovr_wait: got %0d exp 2", rdy_t.size()); end
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b exp 1", valid); end
        n_cmp++;
        if (data !== 8'h10) begin n_bad++; $display("FAIL ovr_hold: got %h exp 10", data); end
        n_cmp++;
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b exp 1", overrun); end
        n_cmp++;
        clr = 1'b1; step(); clr = 1'b0;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr: got %b exp 0", overrun); end
        n_cmp++;
        b = 0;
        while (rdy_t.size() < 3 && b < 200) begin step(); b++; end
        clr = 1'b1; step(); clr = 1'b0;
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_setwins: got %b exp 1", overrun); end
        n_cmp++;
        if (data !== 8'h10) begin n_bad++; $display("FAIL ovr_hold2: got %h exp 10", data); end
        n_cmp++;
        en = 1'b0; ready = 1'b1;
        step();
        if (valid !== 1'b0) begin n_bad++; $display("FAIL ovr_drain: got %b exp 0", valid); end
        n_cmp++;
        if (xfer_q.size() !== 1) begin n_bad++; $display("FAIL ovr_nxfer: got %0d exp 1", xfer_q.size()); end
        else begin
            if (xfer_q[0] !== 8'h10) begin n_bad++; $display("FAIL ovr_xfer: got %h exp 10", xfer_q[0]); end
            n_cmp++;
        end
        n_cmp++;
        repeat (30) step();
    endtask

    task automatic test_en_drop();
        int b = 0;
        logic [RES-1:0] v;
        reset_dut();
        period = DW'(20); avg_log2 = KW'(3); ready = 1'b1;
        en = 1'b1;
        while (start_t.size() < 6 && b < 400) begin step(); b++; end
        en = 1'b0;
        repeat (60) step();
        if (start_t.size() !== 6) begin n_bad++; $display("FAIL drop_starts: got %0d exp 6", start_t.size()); end
        n_cmp++;
        if (rdy_t.size() !== 6) begin n_bad++; $display("FAIL drop_convs: got %0d exp 6", rdy_t.size()); end
        n_cmp++;
        if (vrise_t.size() !== 0) begin n_bad++; $display("FAIL drop_valid: got %0d exp 0", vrise_t.size()); end
        n_cmp++;
        v = RES'($urandom);
        res_q.push_back(v);
        avg_log2 = '0; en = 1'b1;
        b = 0;
        while (xfer_q.size() < 1 && b < 100) begin step(); b++; end
        en = 1'b0;
        if (xfer_q.size() < 1) begin n_bad++; $display("FAIL drop_reen: got %0d xfers exp 1", xfer_q.size()); end
        else begin
            if (xfer_q[0] !== v) begin n_bad++; $display("FAIL drop_alone: got %h exp %h", xfer_q[0], v); end
            n_cmp++;
        end
        n_cmp++;
        repeat (30) step();
    endtask

    task automatic test_reset_mid();
        int b = 0;
        int c0;
        reset_dut();
        period = DW'(20); avg_log2 = '0; ready = 1'b0;
        en = 1'b1;
        while (start_t.size() < 3 && b < 400) begin step(); b++; end
        if (start !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_start: got %b exp 1", start); end
        n_cmp++;
        if (valid !== 1'b1 || overrun !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got valid %b overrun %b exp 1 1", valid, overrun); end
        n_cmp++;
        #2; rst_n = 1'b0; #1;
        if (start !== 1'b0) begin n_bad++; $display("FAIL rmid_start: got %b exp 0", start); end
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b exp 0", valid); end
        n_cmp++;
        if (data !== 8'h00) begin n_bad++; $display("FAIL rmid_data: got %h exp 00", data); end
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL rmid_overrun: got %b exp 0", overrun); end
        n_cmp++;
        en = 1'b0; rdy = 1'b0; cd = 0; ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        clear_mon();
        repeat (40) step();
        if (start_t.size() !== 0) begin n_bad++; $display("FAIL rmid_idle: got %0d starts exp 0", start_t.size()); end
        n_cmp++;
        en = 1'b1; c0 = cyc; b = 0;
        while (start_t.size() < 1 && b < 100) begin step(); b++; end
        en = 1'b0;
        if (start_t.size() < 1) begin n_bad++; $display("FAIL rmid_restart: got 0 starts exp 1"); end
        else begin
            if (start_t[0] !== c0 + 21) begin n_bad++; $display("FAIL rmid_first: got %0d exp %0d", start_t[0], c0 + 21); end
            n_cmp++;
        end
        n_cmp++;
        repeat (30) step();
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int b = 0;
            int p, kin, keff, n, g, c0, pe, sum, exp_v;
            reset_dut();
            p    = int'($urandom_range(0, 40));
            kin  = int'($urandom_range(0, 7));
            keff = (kin > AMAX) ? AMAX : kin;
            n    = 1 << keff;
            g    = (keff >= 3) ? 1 : 2;
            pe   = eff_period(p);
            period = DW'(p); avg_log2 = KW'(kin); ready = 1'b1;
            for (int j = 0; j < n * g; j++) begin
                if (j == 0) res_q.push_back(8'hFF);
                else res_q.push_back(RES'($urandom));
            end
            en = 1'b1; c0 = cyc;
            while (rdy_t.size() < n * g && b < n * g * 45 + 100) begin step(); b++; end
            step(); step();
            en = 1'b0;
            if (start_t.size() < 1 || start_t[0] !== c0 + pe + 1) begin
                n_bad++; $display("FAIL rnd_first: period %0d got %0d exp %0d", p, (start_t.size() > 0) ? start_t[0] : -1, c0 + pe + 1);
            end
            n_cmp++;
            for (int i = 1; i < start_t.size(); i++) begin
                if (start_t[i] - start_t[i-1] !== pe) begin
                    n_bad++; $display("FAIL rnd_spacing: got %0d exp %0d", start_t[i] - start_t[i-1], pe);
                end
                n_cmp++;
            end
            if (xfer_q.size() !== g) begin n_bad++; $display("FAIL rnd_nxfer: k %0d got %0d exp %0d", kin, xfer_q.size(), g); end
            n_cmp++;
            for (int gi = 0; gi < g && gi < xfer_q.size(); gi++) begin
                sum = 0;
                for (int j = 0; j < n; j++) sum += int'(used_q[gi * n + j]);
                exp_v = ref_avg(sum, keff);
                if (int'(xfer_q[gi]) !== exp_v) begin n_bad++; $display("FAIL rnd_data: k %0d got %0d exp %0d", kin, xfer_q[gi], exp_v); end
                n_cmp++;
            end
            if (overrun !== 1'b0) begin n_bad++; $display("FAIL rnd_overrun: got %b exp 0", overrun); end
            n_cmp++;
            repeat (50) step();
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_min_period();
        test_average();
        test_overrun();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
